// File: rtl/rf_write_arbiter_pkg.sv
// Shared definitions for the register-file write-port controller:
// register file geometry, FSM state encoding and the write request record.
package rf_write_arbiter_pkg;

   localparam int REG_COUNT  = 32;
   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;

   // FSM state encoding, kept as plain constants for legacy compatibility
   localparam logic [0:0] ST_INIT = 1'b0;
   localparam logic [0:0] ST_RUN  = 1'b1;

   typedef struct packed {
      logic [REG_ADDR_W-1:0] addr;
      logic [XLEN-1:0]       data;
   } wr_req_t;

   // x0 is hard-wired to zero, so writes to it must never reach the file
   function automatic logic is_x0(input logic [REG_ADDR_W-1:0] addr);
      return (addr == {REG_ADDR_W{1'b0}});
   endfunction

endpackage

// File: rtl/rf_write_arbiter_if.sv
// Valid/ready write request channel from one writeback source to the arbiter.
interface rf_write_arbiter_if;
   import rf_write_arbiter_pkg::*;

   logic                  valid;
   logic [REG_ADDR_W-1:0] addr;
   logic [XLEN-1:0]       data;
   logic                  ready;

   modport master (output valid, output addr, output data, input ready);
   modport slave  (input valid, input addr, input data, output ready);

endinterface

// File: rtl/rf_write_arbiter_rr_arbiter2.sv
// Two-input round-robin arbiter. Grants are combinational from the valids
// and the pointer; after any grant the pointer moves to the loser so that
// continuous contention alternates between the two requesters.
module rr_arbiter2 (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic valid0,
   input  logic valid1,
   output logic gnt0,
   output logic gnt1
);

   logic ptr_r;
   logic gnt0_s;
   logic gnt1_s;

   // grant selection: a lone requester wins, ties go to the pointer
   always_comb begin
      gnt0_s = 1'b0;
      gnt1_s = 1'b0;
      if (en) begin
         if (valid0 && valid1) begin
            if (ptr_r) begin
               gnt1_s = 1'b1;
            end else begin
               gnt0_s = 1'b1;
            end
         end else begin
            gnt0_s = valid0;
            gnt1_s = valid1;
         end
      end else begin
         gnt0_s = 1'b0;
         gnt1_s = 1'b0;
      end
   end

   // pointer update: point at whichever requester was not granted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr_r <= 1'b0;
      end else if (gnt0_s) begin
         ptr_r <= 1'b1;
      end else if (gnt1_s) begin
         ptr_r <= 1'b0;
      end else begin
         ptr_r <= ptr_r;
      end
   end

   assign gnt0 = gnt0_s;
   assign gnt1 = gnt1_s;

endmodule

// File: rtl/rf_write_arbiter.sv
// Write-port controller for the 32x32 register file: zeroes every register
// after reset, then shares the single write port between two writeback
// sources with round-robin arbitration. The rf_* outputs are registered and
// double as the forwarding source for the pending write.
module rf_write_arbiter
   import rf_write_arbiter_pkg::*;
#(
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                  clk,
   input  logic                  rst,
   rf_write_arbiter_if.slave     req0,
   rf_write_arbiter_if.slave     req1,
   output logic                  rf_we,
   output logic [REG_ADDR_W-1:0] rf_addr,
   output logic [XLEN-1:0]       rf_wdata,
   output logic                  init_done
);

   logic [0:0]            state_r;
   logic [REG_ADDR_W-1:0] clr_cnt_r;
   logic                  rf_we_r;
   logic [REG_ADDR_W-1:0] rf_addr_r;
   logic [XLEN-1:0]       rf_wdata_r;
   logic                  init_done_r;

   logic    run_s;
   logic    gnt0_s;
   logic    gnt1_s;
   logic    hs_s;
   wr_req_t sel_s;

   assign run_s = (state_r == ST_RUN);

   rr_arbiter2 u_arb (
      .clk    (clk),
      .rst    (rst),
      .en     (run_s),
      .valid0 (req0.valid),
      .valid1 (req1.valid),
      .gnt0   (gnt0_s),
      .gnt1   (gnt1_s)
   );

   assign req0.ready = gnt0_s;
   assign req1.ready = gnt1_s;

   // a grant is only ever given to a valid requester, so grant == handshake
   assign hs_s = gnt0_s | gnt1_s;

   // mux the granted requester's address and data
   always_comb begin
      sel_s = '0;
      if (gnt1_s) begin
         sel_s.addr = req1.addr;
         sel_s.data = req1.data;
      end else begin
         sel_s.addr = req0.addr;
         sel_s.data = req0.data;
      end
   end

   // FSM, clear counter and registered write port
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r     <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
         clr_cnt_r   <= {REG_ADDR_W{1'b0}};
         rf_we_r     <= 1'b0;
         rf_addr_r   <= {REG_ADDR_W{1'b0}};
         rf_wdata_r  <= {XLEN{1'b0}};
         init_done_r <= CLEAR_ON_RESET ? 1'b0 : 1'b1;
      end else begin
         case (state_r)
            ST_INIT: begin
               rf_we_r    <= 1'b1;
               rf_addr_r  <= clr_cnt_r;
               rf_wdata_r <= {XLEN{1'b0}};
               clr_cnt_r  <= clr_cnt_r + 5'd1;
               if (clr_cnt_r == REG_ADDR_W'(REG_COUNT - 1)) begin
                  state_r <= ST_RUN;
               end else begin
                  state_r <= ST_INIT;
               end
            end
            ST_RUN: begin
               // init_done lags the state change by one edge so it rises
               // on the same edge that retires the last clear write
               init_done_r <= 1'b1;
               if (hs_s) begin
                  rf_we_r    <= ~is_x0(sel_s.addr);
                  rf_addr_r  <= sel_s.addr;
                  rf_wdata_r <= sel_s.data;
               end else begin
                  rf_we_r <= 1'b0;
               end
            end
            default: begin
               state_r <= ST_INIT;
               rf_we_r <= 1'b0;
            end
         endcase
      end
   end

   assign rf_we     = rf_we_r;
   assign rf_addr   = rf_addr_r;
   assign rf_wdata  = rf_wdata_r;
   assign init_done = init_done_r;

endmodule
